lapido_multicycle_control: RTL and testbench

//  Multi-cycle control FSM for the Lapido datapath; replaces the single-edge opcode decoder.

---
 rtl/lapido_multicycle_control.sv | 160 ++++++++++++++++
 tb/tb_lapido_multicycle_control.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/lapido_multicycle_control.sv
// lapido_multicycle_control: multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK
// control FSM for the Lapido datapath. Memory strobes are active-low.
// Optional feature: define LAPIDO_CTRL_ILLEGAL_TRAP_EN to trap unknown
// instruction classes in a HALT state (illegal=1) instead of treating them as NOPs.
module lapido_multicycle_control #(
    parameter int INSTR_WIDTH     = 32,
    parameter int ALUOP_WIDTH     = 5,
    parameter int MEM_WAIT_CYCLES = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [INSTR_WIDTH-1:0] instruction,
    output logic                   branch,
    output logic                   memRead,
    output logic                   memWrite,
    output logic                   memToReg,
    output logic [ALUOP_WIDTH-1:0] ALUOp,
    output logic                   ALUSrc,
    output logic                   regWrite,
    output logic                   enablePC,
    output logic                   irWrite,
    output logic                   illegal
);

    localparam logic [2:0] S_FETCH     = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_EXECUTE   = 3'd2;
    localparam logic [2:0] S_MEMORY    = 3'd3;
    localparam logic [2:0] S_WRITEBACK = 3'd4;
`ifdef LAPIDO_CTRL_ILLEGAL_TRAP_EN
    localparam logic [2:0] S_HALT      = 3'd5;
`endif

    localparam logic [2:0] CLS_ALU = 3'b001;
    localparam logic [2:0] CLS_MEM = 3'b100;
    localparam logic [2:0] CLS_BR  = 3'b010;

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT_CYCLES);

    logic [2:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] cls_q, cls_d;
    logic       ls_q, ls_d;
    logic [4:0] op_q, op_d;

    // Only the class, ls and op fields are decoded; the remaining bits are don't-care.
    logic unused_instr;
    assign unused_instr = ^instruction;

    // Next-state, wait-counter and field-latch logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        cls_d   = cls_q;
        ls_d    = ls_q;
        op_d    = op_q;
        case (state_q)
            S_FETCH: begin
                if (cnt_q == WAIT_LAST) state_d = S_DECODE;
                else                    cnt_d   = cnt_q + 4'd1;
            end
            S_DECODE: begin
                cls_d = instruction[INSTR_WIDTH-1 -: 3];
                ls_d  = instruction[INSTR_WIDTH-8];
                op_d  = instruction[INSTR_WIDTH-4 -: 5];
                case (cls_d)
                    CLS_ALU, CLS_MEM, CLS_BR: state_d = S_EXECUTE;
`ifdef LAPIDO_CTRL_ILLEGAL_TRAP_EN
                    default:                  state_d = S_HALT;
`else
                    default:                  state_d = S_FETCH;
`endif
                endcase
            end
            S_EXECUTE: begin
                case (cls_q)
                    CLS_ALU: state_d = S_WRITEBACK;
                    CLS_MEM: state_d = S_MEMORY;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMORY: begin
                if (cnt_q == WAIT_LAST) state_d = ls_q ? S_FETCH : S_WRITEBACK;
                else                    cnt_d   = cnt_q + 4'd1;
            end
            S_WRITEBACK: state_d = S_FETCH;
`ifdef LAPIDO_CTRL_ILLEGAL_TRAP_EN
            S_HALT:      state_d = S_HALT;
`endif
            default:     state_d = S_FETCH;
        endcase
    end

    // State registers; reset aborts any in-flight access and clears latched fields.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            cls_q   <= '0;
            ls_q    <= 1'b0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cls_q   <= cls_d;
            ls_q    <= ls_d;
            op_q    <= op_d;
        end
    end

    // Moore output decode; outputs held idle while reset is asserted so that
    // the first cycle after reset release is a genuine FETCH with counter 0.
    always_comb begin
        branch   = 1'b0;
        memRead  = 1'b1;
        memWrite = 1'b1;
        memToReg = 1'b0;
        ALUOp    = '0;
        ALUSrc   = 1'b0;
        regWrite = 1'b0;
        enablePC = 1'b0;
        irWrite  = 1'b0;
        illegal  = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    memRead = 1'b0;
                    if (cnt_q == WAIT_LAST) begin
                        irWrite  = 1'b1;
                        enablePC = 1'b1;
                    end
                end
                S_EXECUTE: begin
                    case (cls_q)
                        CLS_ALU: ALUOp[4:0] = op_q;
                        CLS_MEM: ALUSrc     = 1'b1;
                        CLS_BR: begin
                            ALUOp[4:0] = 5'b00001;
                            branch     = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_MEMORY: begin
                    if (ls_q) memWrite = 1'b0;
                    else      memRead  = 1'b0;
                end
                S_WRITEBACK: begin
                    regWrite = 1'b1;
                    memToReg = (cls_q == CLS_MEM);
                end
`ifdef LAPIDO_CTRL_ILLEGAL_TRAP_EN
                S_HALT: illegal = 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lapido_multicycle_control.sv
// Testbench for lapido_multicycle_control: two instances (W=0 and W=2) checked
// cycle by cycle against a phase-list model of each instruction class.
module tb_lapido_multicycle_control;

    logic        clock = 1'b0;
    logic        rst   [2];
    logic [31:0] instr [2];

    logic       br0, mr0, mw0, m2r0, src0, rw0, pc0, ir0, il0;
    logic [4:0] op0;
    logic       br1, mr1, mw1, m2r1, src1, rw1, pc1, ir1, il1;
    logic [4:0] op1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [13:0] exp_q[$];

    always #5 clock = ~clock;

    lapido_multicycle_control #(.INSTR_WIDTH(32), .ALUOP_WIDTH(5), .MEM_WAIT_CYCLES(0)) dut0 (
        .clock(clock), .reset(rst[0]), .instruction(instr[0]),
        .branch(br0), .memRead(mr0), .memWrite(mw0), .memToReg(m2r0), .ALUOp(op0),
        .ALUSrc(src0), .regWrite(rw0), .enablePC(pc0), .irWrite(ir0), .illegal(il0)
    );

    lapido_multicycle_control #(.INSTR_WIDTH(32), .ALUOP_WIDTH(5), .MEM_WAIT_CYCLES(2)) dut1 (
        .clock(clock), .reset(rst[1]), .instruction(instr[1]),
        .branch(br1), .memRead(mr1), .memWrite(mw1), .memToReg(m2r1), .ALUOp(op1),
        .ALUSrc(src1), .regWrite(rw1), .enablePC(pc1), .irWrite(ir1), .illegal(il1)
    );

    wire [13:0] obs0 = {br0, mr0, mw0, m2r0, op0, src0, rw0, pc0, ir0, il0};
    wire [13:0] obs1 = {br1, mr1, mw1, m2r1, op1, src1, rw1, pc1, ir1, il1};

    function automatic logic [13:0] cur(input int d);
        return (d == 0) ? obs0 : obs1;
    endfunction

    function automatic int unsigned wait_of(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    // Output vector: {branch, memRead, memWrite, memToReg, ALUOp, ALUSrc, regWrite, enablePC, irWrite, illegal}
    function automatic logic [13:0] vec(input logic b, input logic mr, input logic mw, input logic m2r,
                                        input logic [4:0] op, input logic src, input logic rw,
                                        input logic pc, input logic ir, input logic il);
        return {b, mr, mw, m2r, op, src, rw, pc, ir, il};
    endfunction

    function automatic logic [13:0] idle();
        return vec(0, 1, 1, 0, 5'd0, 0, 0, 0, 0, 0);
    endfunction

    // Expected cycle-by-cycle outputs for one instruction, FETCH start to next FETCH start.
    task automatic build_expected(input int unsigned w, input logic [31:0] ins);
        logic [2:0] cls;
        logic [4:0] op;
        logic       ls;
        cls = ins[31:29];
        op  = ins[28:24];
        ls  = ins[24];
        exp_q.delete();
        for (int unsigned i = 0; i <= w; i++)
            exp_q.push_back(vec(0, 0, 1, 0, 5'd0, 0, 0, i == w, i == w, 0));
        exp_q.push_back(idle());
        case (cls)
            3'b001: begin
                exp_q.push_back(vec(0, 1, 1, 0, op, 0, 0, 0, 0, 0));
                exp_q.push_back(vec(0, 1, 1, 0, 5'd0, 0, 1, 0, 0, 0));
            end
            3'b100: begin
                exp_q.push_back(vec(0, 1, 1, 0, 5'd0, 1, 0, 0, 0, 0));
                for (int unsigned i = 0; i <= w; i++)
                    exp_q.push_back(ls ? vec(0, 1, 0, 0, 5'd0, 0, 0, 0, 0, 0)
                                       : vec(0, 0, 1, 0, 5'd0, 0, 0, 0, 0, 0));
                if (!ls) exp_q.push_back(vec(0, 1, 1, 1, 5'd0, 0, 1, 0, 0, 0));
            end
            3'b010: exp_q.push_back(vec(1, 1, 1, 0, 5'd1, 0, 0, 0, 0, 0));
            default: begin
`ifdef LAPIDO_CTRL_ILLEGAL_TRAP_EN
                for (int i = 0; i < 4; i++)
                    exp_q.push_back(vec(0, 1, 1, 0, 5'd0, 0, 0, 0, 0, 1));
`endif
            end
        endcase
    endtask

    task automatic check_cycle(input int d, input string name, input int k, input logic [13:0] e);
        total_cnt++;
        if (cur(d) !== e)
            $display("FAIL %s dut%0d cycle %0d: got %b expected %b", name, d, k, cur(d), e);
        else
            pass_cnt++;
    endtask

    // Runs one instruction from its first FETCH cycle; scrambles the
    // instruction bus right after DECODE to show fields are latched.
    task automatic run_instr(input int d, input logic [31:0] ins, input string name);
        int unsigned w;
        w = wait_of(d);
        build_expected(w, ins);
        instr[d] = ins;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clock);
            check_cycle(d, name, k, exp_q[k]);
            @(posedge clock);
            #1;
            if (k == int'(w) + 1) instr[d] = $urandom;
        end
    endtask

    task automatic do_reset(input int d);
        rst[d] = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            check_cycle(d, "reset_idle", c, idle());
            @(posedge clock);
            #1;
        end
        rst[d] = 1'b0;
    endtask

    task automatic test_reset();
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            check_cycle(0, "reset", c, idle());
            check_cycle(1, "reset", c, idle());
            @(posedge clock);
            #1;
        end
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clock);
        check_cycle(0, "reset_release_fetch", 0, vec(0, 0, 1, 0, 5'd0, 0, 0, 1, 1, 0));
        check_cycle(1, "reset_release_fetch", 0, vec(0, 0, 1, 0, 5'd0, 0, 0, 0, 0, 0));
        @(posedge clock);
        #1;
        do_reset(0);
        do_reset(1);
    endtask

    task automatic test_alu();
        run_instr(0, 32'h2A00_0000, "alu_op0a");
        run_instr(0, 32'h3F12_3456, "alu_op1f");
    endtask

    task automatic test_branch();
        run_instr(0, 32'h4000_0000, "branch");
    endtask

    task automatic test_store();
        run_instr(0, 32'h8100_0000, "store");
    endtask

    task automatic test_load_wait();
        run_instr(1, 32'h8000_0000, "load_w2");
        run_instr(1, 32'h81FF_FFFF, "store_w2");
        run_instr(1, 32'h2A00_0000, "alu_w2");
        run_instr(1, 32'h4000_0000, "branch_w2");
    endtask

    // Reset asserted during the first MEMORY cycle must abort the access.
    task automatic test_reset_mid(input int d, input logic [31:0] ins, input string name);
        int unsigned w;
        w = wait_of(d);
        build_expected(w, ins);
        instr[d] = ins;
        for (int k = 0; k <= int'(w) + 3; k++) begin
            @(negedge clock);
            check_cycle(d, name, k, exp_q[k]);
            if (k == int'(w) + 3) rst[d] = 1'b1;
            @(posedge clock);
            #1;
            if (k == int'(w) + 1) instr[d] = $urandom;
        end
        @(negedge clock);
        check_cycle(d, {name, "_abort"}, 0, idle());
        @(posedge clock);
        #1;
        rst[d] = 1'b0;
        run_instr(d, 32'h2100_0000, {name, "_after"});
    endtask

    task automatic test_illegal(input int d);
        run_instr(d, 32'hE000_0000, "unknown_cls");
`ifdef LAPIDO_CTRL_ILLEGAL_TRAP_EN
        do_reset(d);
`else
        run_instr(d, 32'h0000_0000, "unknown_cls0");
`endif
    endtask

    task automatic test_back_to_back(input int d, input int n);
        logic [31:0] ins;
        int          kind;
        for (int i = 0; i < n; i++) begin
            ins  = $urandom;
`ifdef LAPIDO_CTRL_ILLEGAL_TRAP_EN
            kind = $urandom_range(0, 2);
`else
            kind = $urandom_range(0, 3);
`endif
            case (kind)
                0: ins[31:29] = 3'b001;
                1: ins[31:29] = 3'b100;
                2: ins[31:29] = 3'b010;
                default: ins[31:29] = (ins[29] ? 3'b111 : 3'b011);
            endcase
            run_instr(d, ins, "random");
        end
    endtask

    initial begin
        rst[0]   = 1'b1;
        rst[1]   = 1'b1;
        instr[0] = '0;
        instr[1] = '0;
        test_reset();
        test_alu();
        test_branch();
        test_store();
        test_reset_mid(0, 32'h8100_0000, "store_reset");
        test_back_to_back(0, 40);
        test_illegal(0);
        do_reset(1);
        test_load_wait();
        test_reset_mid(1, 32'h8000_0000, "load_reset_w2");
        test_back_to_back(1, 30);
        test_illegal(1);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
